er_dma_sched: RTL and testbench
===============================

// Module: er_dma_sched
// PURPOSE
//  Schedules the shared memory bus between the CPU running the Executable Region (ER) and the DMA engine.
//  Holds ER bounds in lockable config registers and drives them to the ER execution monitor.
//  Defers DMA grants while the CPU executes inside the ER.
//  Forces a grant after a bounded wait and pulses exec_abort so attestation sees the ER run as invalid.
// PARAMETERS
//  TMO_W        8      width of wait counter and timeout register
//  DEF_TMO      8'd64  timeout reset value in cycles; 0 = never force a grant
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   reset, synchronous, active-low
//  pc           in   16  current CPU program counter
//  cfg_we       in   1   config write strobe
//  cfg_addr     in   2   0=ER_min, 1=ER_max, 2=timeout, 3=reserved (writes ignored)
//  cfg_wdata    in   16  write data; timeout uses [TMO_W-1:0]
//  cfg_lock     in   1   sets the lock bit, which stays set until reset
//  dma_req      in   1   DMA bus request, level
//  dma_grant    out  1   DMA bus grant, registered
//  ER_min       out  16  ER lower bound, to the monitor
//  ER_max       out  16  ER upper bound, to the monitor
//  in_er        out  1   registered: pc is inside [ER_min, ER_max]
//  exec_abort   out  1   one-cycle pulse when a grant is forced inside the ER
//  locked       out  1   lock bit
// BEHAVIOUR
//  Reset (rst_n=0 at posedge clk):
//   - Outputs: ER_min=16'hFFFF, ER_max=16'h0000 (empty region), dma_grant=0, in_er=0, exec_abort=0, locked=0.
//   - Internal: timeout=DEF_TMO, wait_cnt=0, state=FREE.
//   - Applies mid-operation, including in HOLD or FORCED.
//  Range: in_range = (pc>=ER_min)&&(pc<=ER_max), unsigned. If ER_min>ER_max the region is empty and in_range=0.
//   in_er <= in_range every cycle.
//  Config:
//   - A write takes effect at the next edge.
//   - Writes are ignored when locked=1 or when state!=FREE.
//   - cfg_lock and cfg_we in the same cycle: the write lands, then lock sets.
//  FSM, 3 states:
//   - FREE:
//     - dma_grant <= dma_req (1-cycle latency).
//     - pc==ER_min (ER entry point) -> HOLD, with dma_grant <= 0 at the same edge, even if dma_req=1.
//     - pc inside the ER but !=ER_min (illegal entry): stay FREE, grant unaffected. The monitor flags that run.
//   - HOLD:
//     - dma_grant=0.
//     - wait_cnt increments while dma_req=1 and holds while dma_req=0. It saturates at all-ones.
//     - pc outside the range -> FREE, wait_cnt <= 0. The grant is issued from the next FREE cycle.
//     - timeout!=0 && dma_req && wait_cnt==timeout-1 -> FORCED; same edge: dma_grant<=1, exec_abort<=1.
//     - Exit takes priority over the timeout when both occur in the same cycle.
//   - FORCED:
//     - dma_grant <= dma_req.
//     - exec_abort is high only for the entry cycle.
//     - pc outside the range -> FREE, wait_cnt <= 0.
//     - pc==ER_min again does not return to HOLD until the FSM has passed through FREE.
//  exec_abort is registered and 0 in every cycle except the FORCED entry cycle.
//  Grant withdrawal on entry to HOLD is immediate. The DMA engine must stall on grant drop.
//   No handshake acknowledge exists.
// STRUCTURE
//  Package er_sched_pkg:
//   - state encoding: FREE=2'd0, HOLD=2'd1, FORCED=2'd2
//   - cfg address constants: CFG_ERMIN, CFG_ERMAX, CFG_TMO
//   - reset constants: ERMIN_RST, ERMAX_RST
//  Sub-module er_range_cmp: combinational pc-vs-[min,max] compare plus the pc==min test.
//   It is shared with the monitor integration.
//  Top level: config registers, FSM, wait counter, output registers.
// TESTING
//  1 Reset, then dma_req=1 with pc outside the ER -> dma_grant=1 one cycle later. ER_min=FFFF, ER_max=0000, exec_abort=0.
//  2 Program ER 0xE000..0xE0FF. In FREE with grant=1, pc=0xE000 -> next edge grant=0 and HOLD.
//    Then pc=0xF000 -> FREE, and grant=1 on the following edge.
//  3 timeout=4, in HOLD with dma_req held at 1 -> grant=1 and exec_abort=1 on the 4th dma_req-high HOLD cycle.
//    exec_abort=0 afterwards. The FSM does not re-enter HOLD at pc=0xE000 until pc has left the ER.
//  4 timeout=0, dma_req=1 for 300 cycles in HOLD -> grant stays 0, wait_cnt saturates at 8'hFF, no abort.
//  5 Lock set, then cfg write ER_min=0x1000 -> ER_min unchanged.
//    An unlocked write during HOLD is also ignored. rst_n=0 clears the lock.
//  6 rst_n=0 asserted in FORCED with grant=1 -> next edge grant=0, state FREE, all registers at reset values.
//    ER_min>ER_max config -> in_er=0 for every pc.

Source files
------------

// File: rtl/er_sched_pkg.sv
// ----------------------------------------------------------------------------
// er_sched_pkg
// Shared types and constants for the ER / DMA bus scheduler.
//   sched_state_t : scheduler FSM encoding (FREE / HOLD / FORCED)
//   CFG_*         : config register addresses on cfg_addr
//   *_RST         : reset values of the ER bounds (empty region)
// ----------------------------------------------------------------------------
package er_sched_pkg;

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_FORCED = 2'd2
    } sched_state_t;

    localparam logic [1:0] CFG_ERMIN = 2'd0;
    localparam logic [1:0] CFG_ERMAX = 2'd1;
    localparam logic [1:0] CFG_TMO   = 2'd2;

    // min > max describes an empty region, so nothing is "inside" after reset.
    localparam logic [15:0] ERMIN_RST = 16'hFFFF;
    localparam logic [15:0] ERMAX_RST = 16'h0000;

endpackage

// File: rtl/er_range_cmp.sv
// ----------------------------------------------------------------------------
// er_range_cmp
// Combinational compare of the program counter against the ER bounds.
// Shared between the scheduler and the execution-monitor integration.
//   i_pc         : current program counter
//   i_min/i_max  : inclusive ER bounds (unsigned)
//   o_in_range   : i_min <= i_pc <= i_max (always 0 when i_min > i_max)
//   o_at_entry   : i_pc is inside the region and equals its entry point i_min
// ----------------------------------------------------------------------------
module er_range_cmp (
    input  logic [15:0] i_pc,
    input  logic [15:0] i_min,
    input  logic [15:0] i_max,
    output logic        o_in_range,
    output logic        o_at_entry
);

    logic w_ge_min;
    logic w_le_max;

    assign w_ge_min   = (i_pc >= i_min);
    assign w_le_max   = (i_pc <= i_max);
    assign o_in_range = w_ge_min && w_le_max;
    // Gating with the range check keeps an empty region from having an entry point.
    assign o_at_entry = o_in_range && (i_pc == i_min);

endmodule

// File: rtl/er_dma_sched.sv
// ----------------------------------------------------------------------------
// er_dma_sched
// Arbitrates the shared memory bus between the CPU executing the Executable
// Region (ER) and the DMA engine. DMA grants are withheld while the CPU runs
// inside the ER; after a bounded wait a grant is forced and exec_abort pulses
// so attestation treats that ER run as invalid.
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   pc                  : CPU program counter
//   cfg_we/addr/wdata   : config write (0=ER_min, 1=ER_max, 2=timeout)
//   cfg_lock            : sticky lock of the config registers until reset
//   dma_req             : DMA request (level)
//   dma_grant           : DMA grant (registered)
//   ER_min, ER_max      : ER bounds to the execution monitor
//   in_er               : registered "pc inside the ER"
//   exec_abort          : one-cycle pulse on a forced grant
//   locked              : lock bit
//   o_dbg_state         : scheduler FSM state
//   o_dbg_wait_cnt      : DMA wait counter
// Handshake: there is no acknowledge. The DMA engine may use the bus in any
// cycle where dma_grant=1 and must stall in the same cycle dma_grant drops.
// ----------------------------------------------------------------------------
module er_dma_sched
    import er_sched_pkg::*;
#(
    parameter int               TMO_W   = 8,
    parameter logic [TMO_W-1:0] DEF_TMO = TMO_W'(64)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [15:0]      pc,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [15:0]      cfg_wdata,
    input  logic             cfg_lock,
    input  logic             dma_req,
    output logic             dma_grant,
    output logic [15:0]      ER_min,
    output logic [15:0]      ER_max,
    output logic             in_er,
    output logic             exec_abort,
    output logic             locked,
    output sched_state_t     o_dbg_state,
    output logic [TMO_W-1:0] o_dbg_wait_cnt
);

    sched_state_t     r_state;
    sched_state_t     w_state_nxt;
    logic [15:0]      r_er_min;
    logic [15:0]      r_er_max;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] r_wait_cnt;
    logic             r_locked;
    logic             r_grant;
    logic             r_abort;
    logic             r_in_er;

    logic             w_in_range;
    logic             w_at_entry;
    logic             w_cfg_wr;
    logic             w_tmo_hit;
    logic [TMO_W-1:0] w_tmo_m1;
    logic [TMO_W-1:0] w_cnt_inc;
    logic [TMO_W-1:0] w_cnt_nxt;
    logic             w_grant_nxt;
    logic             w_abort_nxt;
    logic             w_unused_wdata_hi;

    er_range_cmp u_range (
        .i_pc       (pc),
        .i_min      (r_er_min),
        .i_max      (r_er_max),
        .o_in_range (w_in_range),
        .o_at_entry (w_at_entry)
    );

    // Config is frozen while the ER is being guarded so bounds cannot move
    // under a run in progress.
    assign w_cfg_wr          = cfg_we && !r_locked && (r_state == ST_FREE);
    assign w_unused_wdata_hi = ^cfg_wdata[15:TMO_W];

    assign w_tmo_m1  = r_tmo - TMO_W'(1);
    assign w_tmo_hit = (r_tmo != '0) && dma_req && (r_wait_cnt == w_tmo_m1);
    assign w_cnt_inc = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + TMO_W'(1);

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_FREE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic; leaving the range wins over the timeout.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_FREE:   if (w_at_entry) w_state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (!w_in_range)    w_state_nxt = ST_FREE;
                else if (w_tmo_hit) w_state_nxt = ST_FORCED;
            end
            ST_FORCED: if (!w_in_range) w_state_nxt = ST_FREE;
            default:   w_state_nxt = ST_FREE;
        endcase
    end

    // Output / datapath next values (registered below).
    always_comb begin
        w_grant_nxt = 1'b0;
        w_abort_nxt = 1'b0;
        w_cnt_nxt   = r_wait_cnt;
        case (r_state)
            ST_FREE: begin
                w_cnt_nxt   = '0;
                w_grant_nxt = w_at_entry ? 1'b0 : dma_req;
            end
            ST_HOLD: begin
                if (!w_in_range) begin
                    w_cnt_nxt = '0;
                end else if (w_tmo_hit) begin
                    w_cnt_nxt   = w_cnt_inc;
                    w_grant_nxt = 1'b1;
                    w_abort_nxt = 1'b1;
                end else if (dma_req) begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_FORCED: begin
                w_grant_nxt = dma_req;
                if (!w_in_range) w_cnt_nxt = '0;
            end
            default: w_cnt_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_er_min   <= ERMIN_RST;
            r_er_max   <= ERMAX_RST;
            r_tmo      <= DEF_TMO;
            r_locked   <= 1'b0;
            r_wait_cnt <= '0;
            r_grant    <= 1'b0;
            r_abort    <= 1'b0;
            r_in_er    <= 1'b0;
        end else begin
            r_wait_cnt <= w_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_abort    <= w_abort_nxt;
            r_in_er    <= w_in_range;
            if (w_cfg_wr) begin
                case (cfg_addr)
                    CFG_ERMIN: r_er_min <= cfg_wdata;
                    CFG_ERMAX: r_er_max <= cfg_wdata;
                    CFG_TMO:   r_tmo    <= cfg_wdata[TMO_W-1:0];
                    default:   ;
                endcase
            end
            // Lock is evaluated after the write, so a same-cycle write still lands.
            if (cfg_lock) r_locked <= 1'b1;
        end
    end

    assign dma_grant      = r_grant;
    assign exec_abort     = r_abort;
    assign ER_min         = r_er_min;
    assign ER_max         = r_er_max;
    assign in_er          = r_in_er;
    assign locked         = r_locked;
    assign o_dbg_state    = r_state;
    assign o_dbg_wait_cnt = r_wait_cnt;

endmodule

// File: tb/tb_er_dma_sched.sv
// ----------------------------------------------------------------------------
// tb_er_dma_sched
// Self-checking bench for er_dma_sched: directed sequences for the FSM corner
// cases, a table of range-compare vectors, and an expected queue for the
// grant/abort outputs.
// ----------------------------------------------------------------------------
module tb_er_dma_sched;
    import er_sched_pkg::*;

    logic         clk;
    logic         rst_n;
    logic [15:0]  pc;
    logic         cfg_we;
    logic [1:0]   cfg_addr;
    logic [15:0]  cfg_wdata;
    logic         cfg_lock;
    logic         dma_req;
    logic         dma_grant;
    logic [15:0]  ER_min;
    logic [15:0]  ER_max;
    logic         in_er;
    logic         exec_abort;
    logic         locked;
    sched_state_t dbg_state;
    logic [7:0]   dbg_wait_cnt;

    int total;
    int bad;
    logic [1:0] exp_q[$];   // {grant, abort}

    typedef struct {
        logic [15:0] min;
        logic [15:0] max;
        logic [15:0] pc;
        logic        exp_in;
    } rng_vec_t;

    rng_vec_t vecs[12];

    er_dma_sched dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .cfg_lock       (cfg_lock),
        .dma_req        (dma_req),
        .dma_grant      (dma_grant),
        .ER_min         (ER_min),
        .ER_max         (ER_max),
        .in_er          (in_er),
        .exec_abort     (exec_abort),
        .locked         (locked),
        .o_dbg_state    (dbg_state),
        .o_dbg_wait_cnt (dbg_wait_cnt)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_lock = 1'b0;
        dma_req  = 1'b0;
        pc       = 16'h5555;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [15:0] d);
        cfg_we    = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        tick();
        cfg_we = 1'b0;
    endtask

    // Drive one cycle, queue the expected grant/abort, then pop and compare.
    task automatic step(input logic [15:0] p, input logic req,
                        input logic eg, input logic ea);
        logic [1:0] e;
        pc      = p;
        dma_req = req;
        exp_q.push_back({eg, ea});
        tick();
        if (exp_q.size() == 0) begin
            chk("queue_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk("grant", {31'd0, dma_grant}, {31'd0, e[1]});
            chk("abort", {31'd0, exec_abort}, {31'd0, e[0]});
        end
    endtask

    task automatic chk_state(input string name, input sched_state_t s);
        chk(name, {30'd0, dbg_state}, {30'd0, s});
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cfg_addr  = 2'd0;
        cfg_wdata = 16'd0;

        vecs[0]  = '{16'hE000, 16'hE0FF, 16'hE000, 1'b1};
        vecs[1]  = '{16'hE000, 16'hE0FF, 16'hE0FF, 1'b1};
        vecs[2]  = '{16'hE000, 16'hE0FF, 16'hDFFF, 1'b0};
        vecs[3]  = '{16'hE000, 16'hE0FF, 16'hE100, 1'b0};
        vecs[4]  = '{16'hE000, 16'hE0FF, 16'hE080, 1'b1};
        vecs[5]  = '{16'h0000, 16'hFFFF, 16'h0000, 1'b1};
        vecs[6]  = '{16'h0000, 16'hFFFF, 16'hFFFF, 1'b1};
        vecs[7]  = '{16'h1234, 16'h1234, 16'h1234, 1'b1};
        vecs[8]  = '{16'h8000, 16'h7FFF, 16'h8000, 1'b0};
        vecs[9]  = '{16'h8000, 16'h7FFF, 16'h7FFF, 1'b0};
        vecs[10] = '{16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
        vecs[11] = '{16'hFFFF, 16'h0000, 16'h0000, 1'b0};

        // 1: reset values, then FREE pass-through grant
        do_reset();
        chk("rst_ermin", {16'd0, ER_min}, 32'hFFFF);
        chk("rst_ermax", {16'd0, ER_max}, 32'h0000);
        chk("rst_grant", {31'd0, dma_grant}, 32'd0);
        chk("rst_in_er", {31'd0, in_er}, 32'd0);
        chk("rst_abort", {31'd0, exec_abort}, 32'd0);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk_state("rst_state", ST_FREE);
        step(16'h0100, 1'b1, 1'b1, 1'b0);

        // 2: program ER, entry withdraws grant, exit restores it
        cfg_write(CFG_ERMIN, 16'hE000);
        cfg_write(CFG_ERMAX, 16'hE0FF);
        chk("prog_ermin", {16'd0, ER_min}, 32'hE000);
        chk("prog_ermax", {16'd0, ER_max}, 32'hE0FF);
        chk("prog_grant", {31'd0, dma_grant}, 32'd1);
        step(16'hE000, 1'b1, 1'b0, 1'b0);
        chk_state("entry_hold", ST_HOLD);
        chk("entry_in_er", {31'd0, in_er}, 32'd1);
        step(16'hF000, 1'b1, 1'b0, 1'b0);
        chk_state("exit_free", ST_FREE);
        step(16'hF000, 1'b1, 1'b1, 1'b0);

        // 3: timeout=4 forces grant on the 4th request-high HOLD cycle
        cfg_write(CFG_TMO, 16'd4);
        step(16'hE000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            step(16'hE010, 1'b1, (i == 3), (i == 3));
        chk_state("forced", ST_FORCED);
        step(16'hE000, 1'b1, 1'b1, 1'b0);
        chk_state("no_reentry", ST_FORCED);
        step(16'hF000, 1'b1, 1'b1, 1'b0);
        chk_state("forced_exit", ST_FREE);
        chk("forced_exit_cnt", {24'd0, dbg_wait_cnt}, 32'd0);
        step(16'hE000, 1'b1, 1'b0, 1'b0);
        chk_state("reentry_hold", ST_HOLD);
        step(16'hF000, 1'b0, 1'b0, 1'b0);

        // 4: timeout=0 never forces; counter saturates; HOLD blocks writes
        cfg_write(CFG_TMO, 16'd0);
        step(16'hE000, 1'b1, 1'b0, 1'b0);
        cfg_write(CFG_ERMIN, 16'h1000);
        chk("hold_wr_ignored", {16'd0, ER_min}, 32'hE000);
        for (int i = 0; i < 300; i++)
            step(16'hE050, 1'b1, 1'b0, 1'b0);
        chk_state("tmo0_hold", ST_HOLD);
        chk("tmo0_sat", {24'd0, dbg_wait_cnt}, 32'hFF);
        step(16'hF000, 1'b0, 1'b0, 1'b0);
        chk("tmo0_clr", {24'd0, dbg_wait_cnt}, 32'd0);

        // 5: lock behaviour
        cfg_lock = 1'b1;
        tick();
        cfg_lock = 1'b0;
        chk("lock_set", {31'd0, locked}, 32'd1);
        cfg_write(CFG_ERMIN, 16'h1000);
        chk("lock_wr_ignored", {16'd0, ER_min}, 32'hE000);
        do_reset();
        chk("lock_cleared", {31'd0, locked}, 32'd0);
        chk("lock_rst_ermin", {16'd0, ER_min}, 32'hFFFF);
        cfg_lock = 1'b1;
        cfg_write(CFG_ERMIN, 16'h2000);
        cfg_lock = 1'b0;
        chk("lock_same_wr", {16'd0, ER_min}, 32'h2000);
        chk("lock_same_bit", {31'd0, locked}, 32'd1);
        cfg_write(CFG_ERMIN, 16'h3000);
        chk("lock_after_wr", {16'd0, ER_min}, 32'h2000);

        // 6: reset out of FORCED
        do_reset();
        cfg_write(CFG_ERMIN, 16'hE000);
        cfg_write(CFG_ERMAX, 16'hE0FF);
        cfg_write(CFG_TMO, 16'd2);
        step(16'hE000, 1'b1, 1'b0, 1'b0);
        step(16'hE010, 1'b1, 1'b0, 1'b0);
        step(16'hE010, 1'b1, 1'b1, 1'b1);
        chk_state("f_forced", ST_FORCED);
        step(16'hE010, 1'b1, 1'b1, 1'b0);
        rst_n = 1'b0;
        tick();
        chk("frst_grant", {31'd0, dma_grant}, 32'd0);
        chk_state("frst_state", ST_FREE);
        chk("frst_ermin", {16'd0, ER_min}, 32'hFFFF);
        chk("frst_ermax", {16'd0, ER_max}, 32'h0000);
        chk("frst_abort", {31'd0, exec_abort}, 32'd0);
        chk("frst_in_er", {31'd0, in_er}, 32'd0);
        chk("frst_cnt", {24'd0, dbg_wait_cnt}, 32'd0);
        rst_n = 1'b1;

        // Default timeout of 64 after reset
        cfg_write(CFG_ERMIN, 16'hE000);
        cfg_write(CFG_ERMAX, 16'hE0FF);
        step(16'hE000, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++)
            step(16'hE010, 1'b1, (i == 63), (i == 63));

        // Range-compare table, fresh reset per vector
        for (int i = 0; i < 12; i++) begin
            do_reset();
            cfg_write(CFG_ERMIN, vecs[i].min);
            cfg_write(CFG_ERMAX, vecs[i].max);
            pc = vecs[i].pc;
            tick();
            chk($sformatf("range_vec%0d", i), {31'd0, in_er}, {31'd0, vecs[i].exp_in});
        end

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
